// File: rtl/cart_mapper.sv
// cart_mapper: MBC1 banking registers plus the DMG boot-ROM overlay.
// Turns CPU bus accesses into physical boot/ROM/RAM addresses and returns
// read data one cycle after the request, in step with the 1-cycle memories.
module cart_mapper #(
  parameter int ROM_BANKS_LOG2 = 1,
  parameter int RAM_ADDR_W     = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [15:0]                cpu_addr,
  input  logic [7:0]                 cpu_wdata,
  input  logic                       cpu_wr,
  input  logic                       cpu_rd,
  output logic [7:0]                 rd_data,
  output logic                       rd_valid,
  output logic                       boot_active,
  output logic [7:0]                 boot_addr,
  input  logic [7:0]                 boot_data,
  output logic [14+ROM_BANKS_LOG2-1:0] rom_addr,
  input  logic [7:0]                 rom_data,
  output logic [RAM_ADDR_W-1:0]      ram_addr,
  output logic [7:0]                 ram_wdata,
  output logic                       ram_we,
  input  logic [7:0]                 ram_rdata
);

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_BOOT = 2'd1,
    SEL_ROM  = 2'd2,
    SEL_RAM  = 2'd3
  } sel_t;

  // Banking state
  logic       ram_en;
  logic [4:0] rom_bank5;
  logic [1:0] bank2;
  logic       mode;

  // Read return pipeline: which memory answers the outstanding read
  sel_t       sel_q;
  sel_t       sel_d;

  logic       rd_accept;
  logic       reg_wr;
  logic       boot_clr;
  logic       in_ram_win;
  logic [4:0] eff5;
  logic [6:0] bank;
  logic [31:0] bank_ext;
  logic [31:0] ram_ext;

  // A simultaneous write wins; the read half of the access is dropped.
  assign rd_accept  = cpu_rd & ~cpu_wr;
  assign reg_wr     = cpu_wr & ~cpu_addr[15];
  assign boot_clr   = cpu_wr & (cpu_addr == 16'hFF50) & (cpu_wdata != 8'h00);
  assign in_ram_win = (cpu_addr[15:13] == 3'b101);

  // Address generation from the bus address and current bank registers
  always_comb begin
    boot_addr = cpu_addr[7:0];
    // Bank 0 is remapped to 1 only when all five bits are zero, before any
    // masking to the actual ROM size.
    eff5 = (rom_bank5 == 5'd0) ? 5'd1 : rom_bank5;
    if (cpu_addr[14])
      bank = {bank2, eff5};
    else if (mode)
      bank = {bank2, 5'd0};
    else
      bank = 7'd0;
    bank_ext  = {25'd0, bank};
    rom_addr  = {bank_ext[ROM_BANKS_LOG2-1:0], cpu_addr[13:0]};
    ram_ext   = {17'd0, (mode ? bank2 : 2'b00), cpu_addr[12:0]};
    ram_addr  = ram_ext[RAM_ADDR_W-1:0];
    ram_wdata = cpu_wdata;
    ram_we    = cpu_wr & ram_en & in_ram_win;
  end

  // Read decode: pick the memory that will answer on the next cycle
  always_comb begin
    sel_d = SEL_NONE;
    if (cpu_addr < 16'h0100 && boot_active)
      sel_d = SEL_BOOT;
    else if (!cpu_addr[15])
      sel_d = SEL_ROM;
    else if (in_ram_win && ram_en)
      sel_d = SEL_RAM;
  end

  // Banking registers and the sticky boot-disable latch
  always_ff @(posedge clk) begin
    if (rst) begin
      boot_active <= 1'b1;
      ram_en      <= 1'b0;
      rom_bank5   <= 5'd1;
      bank2       <= 2'd0;
      mode        <= 1'b0;
    end else begin
      // Only ever cleared here; nothing but reset sets it again.
      if (boot_clr)
        boot_active <= 1'b0;
      if (reg_wr) begin
        case (cpu_addr[14:13])
          2'd0: ram_en    <= (cpu_wdata[3:0] == 4'hA);
          2'd1: rom_bank5 <= cpu_wdata[4:0];
          2'd2: bank2     <= cpu_wdata[1:0];
          default: mode   <= cpu_wdata[0];
        endcase
      end
    end
  end

  // Capture the read select so later register changes cannot affect it
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      sel_q    <= SEL_NONE;
    end else begin
      rd_valid <= rd_accept;
      sel_q    <= rd_accept ? sel_d : SEL_NONE;
    end
  end

  // Return mux; idle bus reads as FF
  always_comb begin
    rd_data = 8'hFF;
    if (rd_valid) begin
      case (sel_q)
        SEL_BOOT: rd_data = boot_data;
        SEL_ROM:  rd_data = rom_data;
        SEL_RAM:  rd_data = ram_rdata;
        default:  rd_data = 8'hFF;
      endcase
    end
  end

endmodule

// File: tb/tb_cart_mapper.sv
// Directed bench for cart_mapper with 1-cycle boot/ROM/RAM models.
module tb_cart_mapper;
  localparam int RBL = 7;
  localparam int RW  = 14 + RBL;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   cpu_addr;
  logic [7:0]    cpu_wdata;
  logic          cpu_wr;
  logic          cpu_rd;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic          boot_active;
  logic [7:0]    boot_addr;
  logic [7:0]    boot_data;
  logic [RW-1:0] rom_addr;
  logic [7:0]    rom_data;
  logic [14:0]   ram_addr;
  logic [7:0]    ram_wdata;
  logic          ram_we;
  logic [7:0]    ram_rdata;

  int checks = 0;
  int errors = 0;

  logic [7:0] ram_mem [0:32767];

  cart_mapper #(.ROM_BANKS_LOG2(RBL), .RAM_ADDR_W(15)) dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .rd_data(rd_data), .rd_valid(rd_valid),
    .boot_active(boot_active), .boot_addr(boot_addr), .boot_data(boot_data),
    .rom_addr(rom_addr), .rom_data(rom_data), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] romf(input logic [RW-1:0] a);
    return a[7:0] ^ a[15:8] ^ {a[20:16], 3'b101};
  endfunction

  // Synchronous memory models
  always @(posedge clk) begin
    boot_data <= boot_addr ^ 8'h5A;
    rom_data  <= romf(rom_addr);
    ram_rdata <= ram_mem[ram_addr];
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
  end

  // All drives happen 1 time unit after a rising edge.
  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    cpu_wr = 1'b1; cpu_addr = a; cpu_wdata = d;
    @(posedge clk); #1;
    cpu_wr = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Issue one read, check the physical ROM address before the edge and the
  // returned data after it.
  task automatic rd_chk(input string nm, input logic [15:0] a,
                        input logic chk_rom, input logic [RW-1:0] exp_rom,
                        input logic [7:0] exp_data);
    cpu_rd = 1'b1; cpu_addr = a;
    #1;
    if (chk_rom) begin
      checks++;
      if (rom_addr !== exp_rom) begin
        errors++;
        $display("FAIL %s rom_addr got %h want %h", nm, rom_addr, exp_rom);
      end
    end
    @(posedge clk); #1;
    cpu_rd = 1'b0;
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== exp_data) begin
      errors++;
      $display("FAIL %s rd got v=%b d=%h want v=1 d=%h", nm, rd_valid, rd_data, exp_data);
    end
  endtask

  task automatic test_reset();
    cpu_wr = 0; cpu_rd = 0; cpu_addr = 0; cpu_wdata = 0;
    do_reset();
    checks++;
    if (boot_active !== 1'b1 || rd_valid !== 1'b0 || rd_data !== 8'hFF) begin
      errors++;
      $display("FAIL reset got boot=%b v=%b d=%h want 1 0 ff", boot_active, rd_valid, rd_data);
    end
  endtask

  task automatic test_boot();
    cpu_addr = 16'h00FF; #1;
    checks++;
    if (boot_addr !== 8'hFF) begin
      errors++;
      $display("FAIL boot_addr got %h want ff", boot_addr);
    end
    rd_chk("boot_0000", 16'h0000, 1'b0, '0, 8'h5A);
    rd_chk("boot_00ff", 16'h00FF, 1'b0, '0, 8'hA5);
    rd_chk("boot_0100", 16'h0100, 1'b1, 21'h000100, romf(21'h000100));
  endtask

  task automatic test_boot_disable();
    wr(16'hFF50, 8'h01);
    checks++;
    if (boot_active !== 1'b0) begin
      errors++;
      $display("FAIL ff50_clear boot got %b want 0", boot_active);
    end
    rd_chk("postboot_0000", 16'h0000, 1'b1, 21'h000000, romf(21'h000000));
    wr(16'hFF50, 8'h00);
    wr(16'hFF50, 8'h00);
    checks++;
    if (boot_active !== 1'b0) begin
      errors++;
      $display("FAIL ff50_sticky boot got %b want 0", boot_active);
    end
  endtask

  task automatic test_banking();
    wr(16'h2000, 8'h00);
    rd_chk("bank0_as_1", 16'h4000, 1'b1, 21'h004000, romf(21'h004000));
    wr(16'h2000, 8'h1F);
    wr(16'h4000, 8'h03);
    rd_chk("bank_7f", 16'h7FFF, 1'b1, 21'h1FFFFF, romf(21'h1FFFFF));
    wr(16'h6000, 8'h01);
    rd_chk("mode1_low", 16'h0000, 1'b1, 21'h180000, romf(21'h180000));
    // Only bits [4:0] matter: 0x20 is bank 0, promoted to 1.
    wr(16'h2000, 8'h20);
    rd_chk("bank_20_as_1", 16'h4000, 1'b1, 21'h184000, romf(21'h184000));
  endtask

  task automatic test_ram();
    do_reset();
    cpu_wr = 1'b1; cpu_addr = 16'hA000; cpu_wdata = 8'h55; #1;
    checks++;
    if (ram_we !== 1'b0) begin
      errors++;
      $display("FAIL ram_we_disabled got %b want 0", ram_we);
    end
    @(posedge clk); #1; cpu_wr = 1'b0;
    rd_chk("ram_disabled_rd", 16'hA000, 1'b0, '0, 8'hFF);
    wr(16'h0000, 8'h0A);
    wr(16'h6000, 8'h01);
    wr(16'h4000, 8'h02);
    cpu_wr = 1'b1; cpu_addr = 16'hB123; cpu_wdata = 8'hAA; #1;
    checks++;
    if (ram_we !== 1'b1 || ram_addr !== 15'h5123) begin
      errors++;
      $display("FAIL ram_wr got we=%b a=%h want 1 5123", ram_we, ram_addr);
    end
    @(posedge clk); #1; cpu_wr = 1'b0;
    rd_chk("ram_readback", 16'hB123, 1'b0, '0, 8'hAA);
  endtask

  task automatic test_back_to_back();
    // mode=1, bank2=2, rom_bank5=1 -> switchable bank 0x41
    logic [15:0] addrs [3];
    logic [7:0]  exp   [3];
    addrs[0] = 16'h4000; exp[0] = romf(21'h104000);
    addrs[1] = 16'hB123; exp[1] = 8'hAA;
    addrs[2] = 16'hC000; exp[2] = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      cpu_rd = 1'b1; cpu_addr = addrs[i];
      @(posedge clk); #1;
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp[i]) begin
        errors++;
        $display("FAIL b2b_%0d got v=%b d=%h want v=1 d=%h", i, rd_valid, rd_data, exp[i]);
      end
    end
    cpu_rd = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 8'hFF) begin
      errors++;
      $display("FAIL b2b_idle got v=%b d=%h want 0 ff", rd_valid, rd_data);
    end
  endtask

  task automatic test_rdwr_and_reset();
    cpu_rd = 1'b1; cpu_wr = 1'b1; cpu_addr = 16'h2000; cpu_wdata = 8'h05;
    @(posedge clk); #1;
    cpu_rd = 1'b0; cpu_wr = 1'b0;
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL rdwr_ignored got v=%b want 0", rd_valid);
    end
    rd_chk("rdwr_bank5", 16'h4000, 1'b1, 21'h114000, romf(21'h114000));
    // Reset arriving with a read in flight
    rst = 1'b1; cpu_rd = 1'b1; cpu_addr = 16'h4000;
    @(posedge clk); #1;
    rst = 1'b0; cpu_rd = 1'b0;
    checks++;
    if (rd_valid !== 1'b0 || boot_active !== 1'b1) begin
      errors++;
      $display("FAIL rst_midread got v=%b boot=%b want 0 1", rd_valid, boot_active);
    end
    rd_chk("rst_bank1", 16'h4000, 1'b1, 21'h004000, romf(21'h004000));
    rd_chk("rst_ram_off", 16'hB123, 1'b0, '0, 8'hFF);
    rd_chk("rst_boot_on", 16'h0010, 1'b0, '0, 8'h10 ^ 8'h5A);
  endtask

  initial begin
    rst = 1'b1; cpu_wr = 0; cpu_rd = 0; cpu_addr = 0; cpu_wdata = 0;
    @(posedge clk); #1;
    test_reset();
    test_boot();
    test_boot_disable();
    test_banking();
    test_ram();
    test_back_to_back();
    test_rdwr_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
